uart_rs232_rx: RTL and testbench

UART (RS-232 framing) serial receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity.
- Samples the asynchronous `rx` line at mid-bit using a baud counter derived from the clock frequency.
- Presents each received byte on a parallel bus with a one-cycle valid strobe.
- Sits at the chip's serial input, feeding downstream byte consumers (e.g. a loopback transmitter or command decoder).

---
 rtl/uart_rs232_rx_pkg.sv | 28 ++
 rtl/uart_rs232_rx_baud_gen.sv | 48 ++++
 rtl/uart_rs232_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rs232_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rs232_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rs232_rx_pkg
// Purpose  : Shared definitions for the RS-232 receiver: FSM state encoding,
//            frame constants and the clocks-per-bit calculation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_rs232_rx_pkg;

  // Receiver FSM states, explicit 1-bit encoding.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_t;

  // Frame layout: bit index 0 = start, 1..DATA_BITS = data, then stop.
  localparam int             DATA_BITS    = 8;
  localparam int             BIT_IDX_W    = 4;
  localparam logic [3:0]     STOP_BIT_IDX = 4'd9;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int calc_baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage : uart_rs232_rx_pkg
`default_nettype wire

// File: rtl/uart_rs232_rx_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit timing for the receiver. While enabled, baud_cnt runs
//            0..BAUD_CNT_MAX-1 and bit_idx advances on each wrap. Both
//            counters are held at zero while disabled, so enabling the block
//            starts a frame at bit 0, count 0.
// Ports    : clk          - system clock
//            rst_n        - synchronous active-low reset
//            enable       - high while a frame is being received
//            sample_pulse - one-cycle pulse at the middle of each bit
//            bit_idx      - current bit within the frame (0 = start)
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_rs232_rx_pkg::*;
#(
  parameter int BAUD_CNT_MAX = 5208
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 sample_pulse,
  output logic [BIT_IDX_W-1:0] bit_idx
);

  localparam int                CNT_W    = $clog2(BAUD_CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(BAUD_CNT_MAX / 2 - 1);

  logic [CNT_W-1:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
      bit_idx  <= bit_idx + 1'b1;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign sample_pulse = enable && (baud_cnt == CNT_MID);

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_rs232_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rs232_rx
// Purpose  : RS-232 serial receiver, 8N1, LSB first. The line is synchronised,
//            a falling edge starts a frame, each bit is sampled at mid-bit and
//            a completed frame with a good stop bit is presented on po_data
//            with a one-cycle po_flag strobe.
// Ports    : clk     - system clock, rising edge
//            rst_n   - synchronous active-low reset
//            rx      - asynchronous serial input, idle high
//            po_data - last correctly received byte
//            po_flag - one-cycle strobe, po_data new this cycle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rs232_rx
  import uart_rs232_rx_pkg::*;
#(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag
);

  localparam int BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);

  // --------------------------------------------------------------------------
  // Input conditioning: two metastability flops, then one delay flop for
  // edge detection. All reset to the idle (high) line level so that reset
  // release never looks like a start edge.
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;
  logic rx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  logic fall_edge;
  assign fall_edge = rx_d & ~rx_s;

  // --------------------------------------------------------------------------
  // Bit timing
  // --------------------------------------------------------------------------
  logic                 recv_en;
  logic                 sample_pulse;
  logic [BIT_IDX_W-1:0] bit_idx;

  uart_baud_gen #(
    .BAUD_CNT_MAX (BAUD_CNT_MAX)
  ) u_baud_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (recv_en),
    .sample_pulse (sample_pulse),
    .bit_idx      (bit_idx)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  rx_state_t state;
  rx_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Leaving RECV at mid-stop-bit (good or bad) lets the
  // next frame's start edge follow immediately after a single stop bit.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fall_edge) begin
          state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (sample_pulse) begin
          if ((bit_idx == '0) && rx_s) begin
            // Start bit high at mid-bit: a glitch, not a frame.
            state_nxt = ST_IDLE;
          end else if (bit_idx == STOP_BIT_IDX) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  logic data_sample;
  logic frame_ok;

  always_comb begin
    recv_en     = (state == ST_RECV);
    data_sample = recv_en && sample_pulse &&
                  (bit_idx >= 4'd1) && (bit_idx <= 4'(DATA_BITS));
    frame_ok    = recv_en && sample_pulse && (bit_idx == STOP_BIT_IDX) && rx_s;
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register fills LSB first; po_data only updates on a
  // frame whose stop bit was sampled high.
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] shift_reg;
  logic [BIT_IDX_W-1:0] data_idx;

  assign data_idx = bit_idx - 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      po_data   <= 8'h00;
      po_flag   <= 1'b0;
    end else begin
      if (data_sample) begin
        shift_reg[data_idx[2:0]] <= rx_s;
      end
      if (frame_ok) begin
        po_data <= shift_reg;
      end
      po_flag <= frame_ok;
    end
  end

endmodule : uart_rs232_rx
`default_nettype wire

// File: tb/tb_uart_rs232_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rs232_rx
// Purpose  : Self-checking bench for uart_rs232_rx. Frames are driven on rx
//            by a serial driver that queues the expected byte and start time;
//            a monitor pops and checks data and latency on every po_flag.
//            A short bit period (16 clocks/bit) keeps the run brief.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rs232_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 62_500;
  localparam int B        = 16;              // clocks per bit
  localparam int H        = B / 2;
  localparam int LAT      = 9 * B + H + 3;   // pin start edge -> po_flag

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;

  uart_rs232_rx #(
    .UART_BPS (UART_BPS),
    .CLK_FREQ (CLK_FREQ)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .po_data (po_data),
    .po_flag (po_flag)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned t0;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Drives one frame. Must be called at #1 after a rising edge; returns at
  // the same phase with the line high, so calls chain with no idle gap.
  task automatic send(input logic [7:0] d, input logic stop, input logic exp_flag);
    exp_t e;
    rx = 1'b0;
    if (exp_flag) begin
      e.data = d;
      e.t0   = cyc;
      q.push_back(e);
    end
    repeat (B) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (B) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  // Bounded wait for every queued frame to be reported.
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 2 * B) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d frames outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  logic        prev_flag = 1'b0;
  exp_t        got;
  int unsigned lat;

  always @(negedge clk) begin
    if (po_flag) begin
      check("flag_single_cycle", 32'(prev_flag), 32'd0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_flag: po_flag=1 po_data=0x%0h, expected no flag (cycle %0d)",
                 po_data, cyc);
      end else begin
        got = q.pop_front();
        check("po_data", 32'(po_data), 32'(got.data));
        lat = cyc - got.t0;
        n_cmp++;
        if (lat + 2 < LAT || lat > LAT + 2) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles, expected %0d +/-2", lat, LAT);
        end
      end
    end
    prev_flag = po_flag;
  end

  // Watchdog
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    wait_cycles(3);
    check("reset_po_data", 32'(po_data), 32'h00);
    check("reset_po_flag", 32'(po_flag), 32'd0);
    rst_n = 1'b1;

    // Idle stability
    wait_cycles(2000);
    check("idle_po_data", 32'(po_data), 32'h00);
    check("idle_po_flag", 32'(po_flag), 32'd0);

    // Back-to-back frames shortly after a fresh reset
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(10);
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 1'b1, 1'b1);
    end
    drain();

    // Bit order / patterns
    send(8'hA5, 1'b1, 1'b1);
    send(8'h5A, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h80, 1'b1, 1'b1);
    drain();
    wait_cycles(B);

    // Glitch rejection: low for a quarter bit, well short of mid-bit
    rx = 1'b0;
    wait_cycles(B / 4);
    rx = 1'b1;
    wait_cycles(3 * B);
    check("glitch_po_data_held", 32'(po_data), 32'h80);
    send(8'h3C, 1'b1, 1'b1);
    drain();
    wait_cycles(B);

    // Framing error: stop bit low
    send(8'h55, 1'b0, 1'b0);
    wait_cycles(2 * B);
    check("framing_po_data_held", 32'(po_data), 32'h3C);
    send(8'h99, 1'b1, 1'b1);
    drain();
    wait_cycles(B);

    // Reset during data bit 4 of 0xF0
    fork
      send(8'hF0, 1'b1, 1'b0);
      begin
        wait_cycles(5 * B + H);
        rst_n = 1'b0;
        wait_cycles(2);
        check("midreset_po_data", 32'(po_data), 32'h00);
        check("midreset_po_flag", 32'(po_flag), 32'd0);
        rst_n = 1'b1;
      end
    join
    wait_cycles(2 * B);
    check("after_midreset_po_data", 32'(po_data), 32'h00);
    send(8'h12, 1'b1, 1'b1);
    drain();
    wait_cycles(2 * B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_rs232_rx
`default_nettype wire
